// File: rtl/systolic_edge_feeder.sv
`default_nettype none
// ============================================================================
// Module   : systolic_edge_feeder
// Purpose  : Edge adapter between a word-level valid/ready host interface and
//            the 4-bit nibble streams of one systolic MAC cell. Buffers word
//            pairs in a small FIFO, serialises them MSB nibble first into
//            4-cycle frames with a 4-bit control word, and reassembles the
//            frames the cell returns RET_LAT_FRAMES frames later.
// Options  : SYSTOLIC_FEEDER_TAG_EN - carry a 2-bit launch sequence tag in
//            ctrl[1:0] and flag any out-of-sequence return on tag_err.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_edge_feeder #(
   parameter int FIFO_DEPTH     = 2,
   parameter int RET_LAT_FRAMES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_col_word,
   input  logic [1:0]  in_col_addr,
   input  logic [15:0] in_row_word,
   input  logic [1:0]  in_row_addr,
   output logic [3:0]  col_data,
   output logic        col_ctrl,
   output logic [3:0]  row_data,
   output logic        row_ctrl,
   input  logic [3:0]  ret_col_data,
   input  logic        ret_col_ctrl,
   input  logic [3:0]  ret_row_data,
   input  logic        ret_row_ctrl,
   output logic [1:0]  phase,
   output logic        out_valid,
   output logic [15:0] out_col_word,
   output logic [1:0]  out_col_addr,
   output logic [15:0] out_row_word,
   output logic [1:0]  out_row_addr,
   output logic        tag_err
);

   localparam int c_PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int c_ENT_W  = 36;
   localparam int c_RCNT_W = $clog2(RET_LAT_FRAMES + 1);
   localparam logic [c_RCNT_W-1:0] c_RET_LAT = c_RCNT_W'(RET_LAT_FRAMES);

   // FIFO entry layout: {col_word, col_addr, row_word, row_addr}
   logic [c_ENT_W-1:0]  r_mem [FIFO_DEPTH];
   logic [c_PTR_W:0]    r_wptr;
   logic [c_PTR_W:0]    r_rptr;
   logic [1:0]          r_phase;

   logic [11:0]         r_col_sh;
   logic [11:0]         r_row_sh;
   logic [2:0]          r_cctrl_sh;
   logic [2:0]          r_rctrl_sh;
   logic [3:0]          r_col_data;
   logic [3:0]          r_row_data;
   logic                r_col_ctrl;
   logic                r_row_ctrl;

   logic [11:0]         r_rc_word;
   logic [11:0]         r_rr_word;
   logic [2:0]          r_rc_ctrl;
   logic [2:0]          r_rr_ctrl;
   logic [c_RCNT_W-1:0] r_ret_cnt;
   logic                r_out_valid;
   logic [15:0]         r_out_col_word;
   logic [1:0]          r_out_col_addr;
   logic [15:0]         r_out_row_word;
   logic [1:0]          r_out_row_addr;

   logic                w_empty;
   logic                w_full;
   logic                w_push;
   logic                w_pop;
   logic                w_launch;
   logic                w_report;
   logic [c_ENT_W-1:0]  w_head;
   logic [c_ENT_W-1:0]  w_lword;
   logic [1:0]          w_ctrl_lo;
   logic [3:0]          w_l_cctrl;
   logic [3:0]          w_l_rctrl;

   assign w_empty  = (r_wptr == r_rptr);
   assign w_full   = (r_wptr[c_PTR_W] != r_rptr[c_PTR_W]) &&
                     (r_wptr[c_PTR_W-1:0] == r_rptr[c_PTR_W-1:0]);
   assign in_ready = !w_full;
   assign w_push   = in_valid && !w_full;
   // Launch happens on the edge that closes phase 3; emptiness is judged on
   // the state before that edge, so a same-edge push waits a whole frame.
   assign w_launch = (r_phase == 2'd3);
   assign w_pop    = w_launch && !w_empty;
   assign w_head   = r_mem[r_rptr[c_PTR_W-1:0]];
   assign w_lword  = w_pop ? w_head : '0;
   assign w_report = w_launch && (r_ret_cnt == c_RET_LAT);

   assign w_l_cctrl = {w_lword[19:18], w_ctrl_lo};
   assign w_l_rctrl = {w_lword[1:0],   w_ctrl_lo};

`ifdef SYSTOLIC_FEEDER_TAG_EN
   logic [1:0] r_tag;
   logic [1:0] r_exp_tag;
   logic       r_tag_err;
   logic [1:0] w_rx_ctag;
   logic [1:0] w_rx_rtag;

   assign w_ctrl_lo = r_tag + 2'd1;
   assign w_rx_ctag = {r_rc_ctrl[0], ret_col_ctrl};
   assign w_rx_rtag = {r_rr_ctrl[0], ret_row_ctrl};
   assign tag_err   = r_tag_err;

   // Launch tag advances on every frame, bubbles included
   always_ff @(posedge clk) begin
      if (!rst_n)        r_tag <= 2'd0;
      else if (w_launch) r_tag <= w_ctrl_lo;
   end

   // Check each reported frame's tags against the expected sequence; sticky error
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_exp_tag <= 2'd0;
         r_tag_err <= 1'b0;
      end else if (w_report) begin
         if ((w_rx_ctag != r_exp_tag) || (w_rx_rtag != r_exp_tag))
            r_tag_err <= 1'b1;
         r_exp_tag <= r_exp_tag + 2'd1;
      end
   end
`else
   assign w_ctrl_lo = 2'b00;
   assign tag_err   = 1'b0;
`endif

   // Free-running frame phase
   always_ff @(posedge clk) begin
      if (!rst_n) r_phase <= 2'd0;
      else        r_phase <= r_phase + 2'd1;
   end

   // Input FIFO storage and pointers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr[c_PTR_W-1:0]] <= {in_col_word, in_col_addr, in_row_word, in_row_addr};
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) r_rptr <= r_rptr + 1'b1;
      end
   end

   // Serialiser: nibble 0 goes straight to the output at launch, the rest shift out
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_col_data <= 4'h0;  r_row_data <= 4'h0;
         r_col_ctrl <= 1'b0;  r_row_ctrl <= 1'b0;
         r_col_sh   <= '0;    r_row_sh   <= '0;
         r_cctrl_sh <= '0;    r_rctrl_sh <= '0;
      end else if (w_launch) begin
         r_col_data <= w_lword[35:32];  r_col_sh <= w_lword[31:20];
         r_row_data <= w_lword[17:14];  r_row_sh <= w_lword[13:2];
         r_col_ctrl <= w_l_cctrl[3];    r_cctrl_sh <= w_l_cctrl[2:0];
         r_row_ctrl <= w_l_rctrl[3];    r_rctrl_sh <= w_l_rctrl[2:0];
      end else begin
         r_col_data <= r_col_sh[11:8];  r_col_sh <= {r_col_sh[7:0], 4'h0};
         r_row_data <= r_row_sh[11:8];  r_row_sh <= {r_row_sh[7:0], 4'h0};
         r_col_ctrl <= r_cctrl_sh[2];   r_cctrl_sh <= {r_cctrl_sh[1:0], 1'b0};
         r_row_ctrl <= r_rctrl_sh[2];   r_rctrl_sh <= {r_rctrl_sh[1:0], 1'b0};
      end
   end

   // Collector: shift in returned nibbles, publish a word pair after the phase-3 sample
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rc_word      <= '0;  r_rr_word      <= '0;
         r_rc_ctrl      <= '0;  r_rr_ctrl      <= '0;
         r_ret_cnt      <= '0;  r_out_valid    <= 1'b0;
         r_out_col_word <= '0;  r_out_col_addr <= '0;
         r_out_row_word <= '0;  r_out_row_addr <= '0;
      end else begin
         r_rc_word   <= {r_rc_word[7:0], ret_col_data};
         r_rr_word   <= {r_rr_word[7:0], ret_row_data};
         r_rc_ctrl   <= {r_rc_ctrl[1:0], ret_col_ctrl};
         r_rr_ctrl   <= {r_rr_ctrl[1:0], ret_row_ctrl};
         r_out_valid <= 1'b0;
         if (w_report) begin
            r_out_valid    <= 1'b1;
            r_out_col_word <= {r_rc_word, ret_col_data};
            r_out_row_word <= {r_rr_word, ret_row_data};
            r_out_col_addr <= r_rc_ctrl[2:1];
            r_out_row_addr <= r_rr_ctrl[2:1];
         end else if (w_launch) begin
            // Frames collected before the pipeline has filled are dropped
            r_ret_cnt <= r_ret_cnt + 1'b1;
         end
      end
   end

   assign phase        = r_phase;
   assign col_data     = r_col_data;
   assign col_ctrl     = r_col_ctrl;
   assign row_data     = r_row_data;
   assign row_ctrl     = r_row_ctrl;
   assign out_valid    = r_out_valid;
   assign out_col_word = r_out_col_word;
   assign out_col_addr = r_out_col_addr;
   assign out_row_word = r_out_row_word;
   assign out_row_addr = r_out_row_addr;

endmodule
`default_nettype wire

// File: tb/tb_systolic_edge_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_edge_feeder
// Purpose  : Scoreboard bench for systolic_edge_feeder with a loopback cell
//            model (returns each frame one frame later).
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_edge_feeder;

   localparam int DEPTH = 2;
   localparam int RL    = 1;
`ifdef SYSTOLIC_FEEDER_TAG_EN
   localparam bit TAG_ON = 1'b1;
`else
   localparam bit TAG_ON = 1'b0;
`endif

   typedef struct packed {
      logic [15:0] cw;
      logic [1:0]  ca;
      logic [15:0] rw;
      logic [1:0]  ra;
   } pair_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_col_word, in_row_word;
   logic [1:0]  in_col_addr, in_row_addr;
   logic [3:0]  col_data, row_data;
   logic        col_ctrl, row_ctrl;
   logic [3:0]  ret_col_data, ret_row_data;
   logic        ret_col_ctrl, ret_row_ctrl;
   logic [1:0]  phase;
   logic        out_valid;
   logic [15:0] out_col_word, out_row_word;
   logic [1:0]  out_col_addr, out_row_addr;
   logic        tag_err;
   logic        corrupt;

   int n_chk  = 0;
   int n_fail = 0;

   systolic_edge_feeder #(.FIFO_DEPTH(DEPTH), .RET_LAT_FRAMES(RL)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_col_word(in_col_word), .in_col_addr(in_col_addr),
      .in_row_word(in_row_word), .in_row_addr(in_row_addr),
      .col_data(col_data), .col_ctrl(col_ctrl),
      .row_data(row_data), .row_ctrl(row_ctrl),
      .ret_col_data(ret_col_data), .ret_col_ctrl(ret_col_ctrl),
      .ret_row_data(ret_row_data), .ret_row_ctrl(ret_row_ctrl),
      .phase(phase), .out_valid(out_valid),
      .out_col_word(out_col_word), .out_col_addr(out_col_addr),
      .out_row_word(out_row_word), .out_row_addr(out_row_addr),
      .tag_err(tag_err)
   );

   always #5 clk = ~clk;

   // Loopback cell: each stream reappears exactly RL frames later
   logic [9:0] lb [4*RL];
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 4*RL; i++) lb[i] <= '0;
      end else begin
         lb[0] <= {col_data, col_ctrl, row_data, row_ctrl};
         for (int i = 1; i < 4*RL; i++) lb[i] <= lb[i-1];
      end
   end
   assign ret_col_data = lb[4*RL-1][9:6];
   assign ret_col_ctrl = lb[4*RL-1][5] ^ corrupt;
   assign ret_row_data = lb[4*RL-1][4:1];
   assign ret_row_ctrl = lb[4*RL-1][0];

   task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: FIFO occupancy, current frame contents, expected returns
   pair_t q_m[$];
   pair_t q_exp[$];
   pair_t m_cur, m_nxt;
   logic [1:0] m_tag;
   int  mcyc = 0;
   int  m_sz;
   bit  m_in_rst = 1'b0;
   bit  m_pend   = 1'b0;
   bit  m_tag_err = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         q_m.delete();
         q_exp.delete();
         q_exp.push_back('0);
         m_cur = '0; m_tag = 2'd0; mcyc = 0;
         m_in_rst = 1'b1; m_pend = 1'b0; m_tag_err = 1'b0;
      end else begin
         m_in_rst = 1'b0;
         m_sz = q_m.size();
         if (mcyc % 4 == 2 && corrupt) m_pend = 1'b1;
         if (mcyc % 4 == 3) begin
            if (m_pend && mcyc >= 4*RL + 3) m_tag_err = TAG_ON;
            m_pend = 1'b0;
            m_nxt = (m_sz > 0) ? q_m.pop_front() : '0;
            m_tag = m_tag + 2'd1;
            m_cur = m_nxt;
            q_exp.push_back(m_nxt);
         end
         if (in_valid && m_sz < DEPTH)
            q_m.push_back({in_col_word, in_col_addr, in_row_word, in_row_addr});
         mcyc++;
      end
   end

   // Monitor: compare every cycle; pop the scoreboard on each out_valid
   int         k;
   logic [3:0] m_cctl, m_rctl;
   pair_t      mon_e;
   always @(negedge clk) begin
      if (!rst_n) begin
         if (m_in_rst) begin
            chk("rst_phase", 36'(phase), 36'd0);
            chk("rst_streams", 36'({col_data, col_ctrl, row_data, row_ctrl}), 36'd0);
            chk("rst_in_ready", 36'(in_ready), 36'd1);
            chk("rst_out_valid", 36'(out_valid), 36'd0);
            chk("rst_out_words", {out_col_word, out_col_addr, out_row_word, out_row_addr}, 36'd0);
            chk("rst_tag_err", 36'(tag_err), 36'd0);
         end
      end else begin
         k = mcyc % 4;
         m_cctl = {m_cur.ca, TAG_ON ? m_tag : 2'b00};
         m_rctl = {m_cur.ra, TAG_ON ? m_tag : 2'b00};
         chk("phase", 36'(phase), 36'(k));
         chk("col_data", 36'(col_data), 36'(m_cur.cw[15-4*k -: 4]));
         chk("row_data", 36'(row_data), 36'(m_cur.rw[15-4*k -: 4]));
         chk("col_ctrl", 36'(col_ctrl), 36'(m_cctl[3-k]));
         chk("row_ctrl", 36'(row_ctrl), 36'(m_rctl[3-k]));
         chk("in_ready", 36'(in_ready), 36'(q_m.size() < DEPTH));
         chk("out_valid", 36'(out_valid), 36'(k == 0 && mcyc >= 4*(RL+1)));
         chk("tag_err", 36'(tag_err), 36'(m_tag_err));
         if (out_valid) begin
            if (q_exp.size() == 0) begin
               chk("scoreboard_empty", 36'd1, 36'd0);
            end else begin
               mon_e = q_exp.pop_front();
               chk("out_pair", {out_col_word, out_col_addr, out_row_word, out_row_addr}, 36'(mon_e));
            end
         end
      end
   end

   task automatic wait_phase(input int ph);
      while (mcyc % 4 != ph) @(negedge clk);
   endtask

   task automatic push_pair(input logic [15:0] cw, input logic [1:0] ca,
                            input logic [15:0] rw, input logic [1:0] ra);
      bit acc = 1'b0;
      int n   = 0;
      in_valid = 1'b1;
      in_col_word = cw; in_col_addr = ca;
      in_row_word = rw; in_row_addr = ra;
      while (!acc && n < 64) begin
         acc = in_ready;
         @(negedge clk);
         n++;
      end
      if (!acc) chk("push_timeout", 36'd0, 36'd1);
   endtask

   logic [3:0] e_cd [4];
   logic [3:0] e_rd [4];
   logic [3:0] e_cc;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; corrupt = 1'b0;
      in_col_word = '0; in_col_addr = '0; in_row_word = '0; in_row_addr = '0;
      e_cd[0] = 4'hA; e_cd[1] = 4'h1; e_cd[2] = 4'hB; e_cd[3] = 4'h2;
      e_rd[0] = 4'h3; e_rd[1] = 4'hC; e_rd[2] = 4'h4; e_rd[3] = 4'hD;
      e_cc = 4'b0100;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);          // bubble frames

      // Single pair, pushed early in the frame; check the next frame directly
      wait_phase(1);
      push_pair(16'hA1B2, 2'd1, 16'h3C4D, 2'd1);
      in_valid = 1'b0;
      wait_phase(0);
      for (int i = 0; i < 4; i++) begin
         chk("frame_col_nib", 36'(col_data), 36'(e_cd[i]));
         chk("frame_row_nib", 36'(row_data), 36'(e_rd[i]));
         chk("frame_col_ctl", 36'(col_ctrl), 36'(e_cc[3-i]));
         @(negedge clk);
      end

      // Loopback word with address 2
      wait_phase(1);
      push_pair(16'h1234, 2'd2, 16'h5678, 2'd2);
      in_valid = 1'b0;
      repeat (12) @(negedge clk);

      // Three pairs back-to-back into a 2-deep FIFO
      wait_phase(0);
      push_pair(16'h1111, 2'd1, 16'h2222, 2'd1);
      push_pair(16'h3333, 2'd2, 16'h4444, 2'd3);
      chk("full_in_ready", 36'(in_ready), 36'd0);
      push_pair(16'h5555, 2'd3, 16'h6666, 2'd2);
      in_valid = 1'b0;
      repeat (16) @(negedge clk);

      // Push on the launch edge with an empty FIFO, then on the edge before it
      wait_phase(3);
      push_pair(16'hBEEF, 2'd1, 16'hCAFE, 2'd2);
      in_valid = 1'b0;
      wait_phase(2);
      push_pair(16'hF00D, 2'd3, 16'h0FF0, 2'd0);
      in_valid = 1'b0;
      repeat (16) @(negedge clk);

      // Flip returned col ctrl bit 1 in one frame
      wait_phase(2);
      corrupt = 1'b1;
      @(negedge clk);
      corrupt = 1'b0;
      repeat (12) @(negedge clk);

      // Reset in the middle of a frame with a pair still queued
      wait_phase(0);
      push_pair(16'h7777, 2'd1, 16'h8888, 2'd1);
      in_valid = 1'b0;
      wait_phase(2);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_phase(1);
      push_pair(16'h9ABC, 2'd2, 16'hDEF0, 2'd3);
      in_valid = 1'b0;
      repeat (16) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
